mem_arbiter: RTL and testbench

MEM_ARBITER -- requirements
Module: mem_arbiter

---
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 301 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// Purpose: arbitrates one single-port asynchronous SRAM between an instruction-fetch
//          read port and a data-stage read/write port; the data stage always wins.
// Latency: WAIT_CYCLES+2 cycles from the accepting edge to the one-cycle ready pulse.
// Backpressure: requesters hold req/operands until ready; if_stall = if_req & ~if_ready.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   if_req/if_addr                fetch request and word address
//   if_rdata/if_ready/if_stall    fetched word, completion pulse, fetch stall
//   mem_req/mem_we/mem_addr/mem_wdata  data-stage request (write when mem_we=1)
//   mem_rdata/mem_ready           load data, completion pulse
//   sram_addr/sram_dout/sram_din  SRAM address, write data, read data
//   sram_ce_n/sram_oe_n/sram_we_n active-low SRAM strobes
//   conflict_cnt                  cycles with both requests pending in IDLE
//
// Build option: define MEM_ARBITER_CONFLICT_CNT_EN to build the saturating
// conflict counter; otherwise conflict_cnt is tied to zero and no register exists.

module mem_arbiter #(
    parameter int WAIT_CYCLES = 1   // SRAM wait states per access, 0..7
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [15:0] if_addr,
    output logic [15:0] if_rdata,
    output logic        if_ready,
    input  logic        mem_req,
    input  logic        mem_we,
    input  logic [15:0] mem_addr,
    input  logic [15:0] mem_wdata,
    output logic [15:0] mem_rdata,
    output logic        mem_ready,
    output logic        if_stall,
    output logic [15:0] sram_addr,
    output logic [15:0] sram_dout,
    input  logic [15:0] sram_din,
    output logic        sram_ce_n,
    output logic        sram_oe_n,
    output logic        sram_we_n,
    output logic [15:0] conflict_cnt
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_DONE   = 2'd2;

    localparam logic [2:0] CNT_LOAD = WAIT_CYCLES[2:0];

    // owner encoding: 1 = data stage, 0 = instruction fetch
    logic [1:0]  state_q, state_d;
    logic [2:0]  cnt_q, cnt_d;
    logic        owner_q, owner_d;
    logic        we_q, we_d;
    logic [15:0] addr_q, addr_d;
    logic [15:0] wdata_q, wdata_d;
    logic [15:0] if_rdata_q, if_rdata_d;
    logic [15:0] mem_rdata_q, mem_rdata_d;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        owner_d     = owner_q;
        we_d        = we_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        if_rdata_d  = if_rdata_q;
        mem_rdata_d = mem_rdata_q;
        case (state_q)
            ST_IDLE: begin
                if (mem_req) begin
                    owner_d = 1'b1;
                    we_d    = mem_we;
                    addr_d  = mem_addr;
                    wdata_d = mem_wdata;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_ACCESS;
                end else if (if_req) begin
                    // wdata is left alone so the SRAM data bus does not toggle on fetches
                    owner_d = 1'b0;
                    we_d    = 1'b0;
                    addr_d  = if_addr;
                    cnt_d   = CNT_LOAD;
                    state_d = ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (cnt_q == 3'd0) begin
                    state_d = ST_DONE;
                    // read data is sampled at the end of the final strobe cycle
                    if (!we_q) begin
                        if (owner_q) begin
                            mem_rdata_d = sram_din;
                        end else begin
                            if_rdata_d = sram_din;
                        end
                    end
                end else begin
                    cnt_d = cnt_q - 3'd1;
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            owner_q     <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= 16'h0000;
            wdata_q     <= 16'h0000;
            if_rdata_q  <= 16'h0000;
            mem_rdata_q <= 16'h0000;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            owner_q     <= owner_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            wdata_q     <= wdata_d;
            if_rdata_q  <= if_rdata_d;
            mem_rdata_q <= mem_rdata_d;
        end
    end

    // Strobes decode straight from the state register so reset releases them at once.
    // Address and data come from the latched operands, which also gives hold time in DONE.
    assign sram_ce_n = ~(state_q == ST_ACCESS);
    assign sram_oe_n = ~((state_q == ST_ACCESS) && !we_q);
    assign sram_we_n = ~((state_q == ST_ACCESS) && we_q);
    assign sram_addr = addr_q;
    assign sram_dout = wdata_q;

    assign if_ready  = (state_q == ST_DONE) && !owner_q;
    assign mem_ready = (state_q == ST_DONE) && owner_q;
    assign if_rdata  = if_rdata_q;
    assign mem_rdata = mem_rdata_q;
    assign if_stall  = if_req && !if_ready;

`ifdef MEM_ARBITER_CONFLICT_CNT_EN
    logic [15:0] conflict_q, conflict_d;

    always_comb begin
        conflict_d = conflict_q;
        if ((state_q == ST_IDLE) && if_req && mem_req && (conflict_q != 16'hFFFF)) begin
            conflict_d = conflict_q + 16'd1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_q <= 16'h0000;
        end else begin
            conflict_q <= conflict_d;
        end
    end

    assign conflict_cnt = conflict_q;
`else
    assign conflict_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Purpose: self-checking bench for mem_arbiter: fixed vector table, random traffic
//          against a word-level memory model, and hand-written multi-cycle sequences.
// Timing: inputs driven 1 time unit after a rising edge, outputs sampled there too.

module tb_mem_arbiter;

    localparam int W = 1;

    logic        clk;
    logic        rst;
    logic        if_req, mem_req, mem_we;
    logic [15:0] if_addr, mem_addr, mem_wdata;
    logic [15:0] if_rdata, mem_rdata, sram_addr, sram_dout, sram_din, conflict_cnt;
    logic        if_ready, mem_ready, if_stall, sram_ce_n, sram_oe_n, sram_we_n;

    // second instance with zero wait states, used for the back-to-back spacing check
    logic        d0_if_req;
    logic [15:0] d0_if_addr;
    logic [15:0] d0_if_rdata, d0_mem_rdata, d0_sram_addr, d0_sram_dout, d0_sram_din, d0_conflict;
    logic        d0_if_ready, d0_mem_ready, d0_if_stall, d0_ce_n, d0_oe_n, d0_we_n;
    logic        d0_mem_req, d0_mem_we;
    logic [15:0] d0_mem_addr, d0_mem_wdata;

    int errors = 0;
    int checks = 0;

    mem_arbiter #(.WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_rdata(if_rdata), .if_ready(if_ready),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ready(mem_ready), .if_stall(if_stall),
        .sram_addr(sram_addr), .sram_dout(sram_dout), .sram_din(sram_din),
        .sram_ce_n(sram_ce_n), .sram_oe_n(sram_oe_n), .sram_we_n(sram_we_n),
        .conflict_cnt(conflict_cnt)
    );

    mem_arbiter #(.WAIT_CYCLES(0)) dut0 (
        .clk(clk), .rst(rst),
        .if_req(d0_if_req), .if_addr(d0_if_addr), .if_rdata(d0_if_rdata), .if_ready(d0_if_ready),
        .mem_req(d0_mem_req), .mem_we(d0_mem_we), .mem_addr(d0_mem_addr), .mem_wdata(d0_mem_wdata),
        .mem_rdata(d0_mem_rdata), .mem_ready(d0_mem_ready), .if_stall(d0_if_stall),
        .sram_addr(d0_sram_addr), .sram_dout(d0_sram_dout), .sram_din(d0_sram_din),
        .sram_ce_n(d0_ce_n), .sram_oe_n(d0_oe_n), .sram_we_n(d0_we_n),
        .conflict_cnt(d0_conflict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural asynchronous SRAM: unwritten words read a fixed pattern.
    logic [15:0] sram [256];
    bit          sram_wr [256];

    function automatic logic [15:0] init_pat(input logic [7:0] a);
        return (a == 8'd4) ? 16'h4F02 : (16'hA500 ^ {8'h00, a});
    endfunction

    always @(posedge clk) begin
        if (!sram_ce_n && !sram_we_n) begin
            sram[sram_addr[7:0]]    <= sram_dout;
            sram_wr[sram_addr[7:0]] <= 1'b1;
        end
    end

    assign sram_din    = sram_wr[sram_addr[7:0]] ? sram[sram_addr[7:0]] : init_pat(sram_addr[7:0]);
    assign d0_sram_din = d0_sram_addr ^ 16'h5A5A;

    // Reference model: memory contents and last value returned to each requester.
    logic [15:0] ref_mem [256];
    logic [15:0] last_if_rd, last_mem_rd;

    function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // One complete transaction; the accepting edge is the first edge after the call.
    task automatic run_and_check(input bit is_mem, input bit we, input logic [15:0] addr,
                                 input logic [15:0] wdata, input logic [15:0] exp_rd);
        int lat = -1;
        int n_strobe = 0;
        int bad_bus = 0;
        int bad_other = 0;
        if (is_mem) begin
            mem_req = 1'b1; mem_we = we; mem_addr = addr; mem_wdata = wdata;
        end else begin
            if_req = 1'b1; if_addr = addr;
        end
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if ((is_mem ? if_ready : mem_ready) !== 1'b0) bad_other++;
            if (is_mem ? mem_ready : if_ready) begin
                // ready is high after edge k, so the requester registers it at edge k+1
                lat = k + 1;
                if (sram_ce_n !== 1'b1 || sram_oe_n !== 1'b1 || sram_we_n !== 1'b1) bad_bus++;
                if (sram_addr !== addr) bad_bus++;
                if (we && sram_dout !== wdata) bad_bus++;
                break;
            end
            if (!sram_ce_n) begin
                n_strobe++;
                if (sram_addr !== addr) bad_bus++;
                if (we) begin
                    if (sram_we_n !== 1'b0 || sram_oe_n !== 1'b1 || sram_dout !== wdata) bad_bus++;
                end else begin
                    if (sram_oe_n !== 1'b0 || sram_we_n !== 1'b1) bad_bus++;
                end
            end else if (!sram_oe_n || !sram_we_n) begin
                bad_bus++;
            end
        end
        chk("latency", 32'(lat), 32'(W + 2));
        chk("strobe_cycles", 32'(n_strobe), 32'(W + 1));
        chk("bus_errs", 32'(bad_bus), 32'd0);
        chk("nonowner_ready", 32'(bad_other), 32'd0);
        if (is_mem) begin
            chk("mem_rdata", 32'(mem_rdata), 32'(exp_rd));
            chk("if_rdata_hold", 32'(if_rdata), 32'(last_if_rd));
        end else begin
            chk("if_rdata", 32'(if_rdata), 32'(exp_rd));
            chk("mem_rdata_hold", 32'(mem_rdata), 32'(last_mem_rd));
        end
        mem_req = 1'b0; if_req = 1'b0;
        if (is_mem && we) ref_mem[addr[7:0]] = wdata;
        if (!we) begin
            if (is_mem) last_mem_rd = exp_rd; else last_if_rd = exp_rd;
        end
        @(posedge clk); #1;
    endtask

    typedef struct {
        bit          is_mem;
        bit          we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_rd;
    } vec_t;

    vec_t tbl[8];

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit          r_mem, r_we;
        logic [15:0] r_addr, r_wdata, r_exp;
        int          km, ki, k1, k2, stall_bad;

        // writes leave mem_rdata alone, so their expected value is the previous load
        tbl[0] = '{1'b0, 1'b0, 16'h0004, 16'h0000, 16'h4F02};
        tbl[1] = '{1'b1, 1'b1, 16'h000F, 16'h0002, 16'h0000};
        tbl[2] = '{1'b1, 1'b0, 16'h000F, 16'h0000, 16'h0002};
        tbl[3] = '{1'b0, 1'b0, 16'h000F, 16'h0000, 16'h0002};
        tbl[4] = '{1'b1, 1'b1, 16'h0004, 16'h1234, 16'h0002};
        tbl[5] = '{1'b0, 1'b0, 16'h0004, 16'h0000, 16'h1234};
        tbl[6] = '{1'b1, 1'b0, 16'h0003, 16'h0000, 16'hA503};
        tbl[7] = '{1'b1, 1'b0, 16'h0004, 16'h0000, 16'h1234};

        for (int i = 0; i < 256; i++) ref_mem[i] = init_pat(8'(i));
        last_if_rd = 16'h0000; last_mem_rd = 16'h0000;

        rst = 1'b1;
        if_req = 1'b0; if_addr = 16'h0; mem_req = 1'b0; mem_we = 1'b0;
        mem_addr = 16'h0; mem_wdata = 16'h0;
        d0_if_req = 1'b0; d0_if_addr = 16'h0; d0_mem_req = 1'b0; d0_mem_we = 1'b0;
        d0_mem_addr = 16'h0; d0_mem_wdata = 16'h0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ce_n", 32'(sram_ce_n), 32'd1);
        chk("rst_oe_n", 32'(sram_oe_n), 32'd1);
        chk("rst_we_n", 32'(sram_we_n), 32'd1);
        chk("rst_if_ready", 32'(if_ready), 32'd0);
        chk("rst_mem_ready", 32'(mem_ready), 32'd0);
        chk("rst_if_rdata", 32'(if_rdata), 32'd0);
        chk("rst_mem_rdata", 32'(mem_rdata), 32'd0);
        chk("rst_sram_addr", 32'(sram_addr), 32'd0);
        chk("rst_sram_dout", 32'(sram_dout), 32'd0);
        chk("rst_conflict", 32'(conflict_cnt), 32'd0);
        rst = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 8; i++) begin
            run_and_check(tbl[i].is_mem, tbl[i].we, tbl[i].addr, tbl[i].wdata, tbl[i].exp_rd);
        end

        for (int i = 0; i < 40; i++) begin
            r_mem   = 1'($urandom_range(0, 1));
            r_we    = r_mem ? 1'($urandom_range(0, 1)) : 1'b0;
            r_addr  = 16'($urandom_range(0, 15));
            r_wdata = 16'($urandom);
            r_exp   = r_we ? last_mem_rd : ref_mem[r_addr[7:0]];
            run_and_check(r_mem, r_we, r_addr, r_wdata, r_exp);
        end

        // Reset in the first ACCESS cycle aborts the read with no ready pulse.
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h0005;
        @(posedge clk); #1;
        chk("abort_in_access", 32'(sram_oe_n), 32'd0);
        rst = 1'b1;
        #1;
        chk("abort_ce_n", 32'(sram_ce_n), 32'd1);
        chk("abort_oe_n", 32'(sram_oe_n), 32'd1);
        chk("abort_mem_ready", 32'(mem_ready), 32'd0);
        chk("abort_mem_rdata", 32'(mem_rdata), 32'd0);
        chk("abort_if_rdata", 32'(if_rdata), 32'd0);
        chk("abort_sram_addr", 32'(sram_addr), 32'd0);
        mem_req = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        last_if_rd = 16'h0000; last_mem_rd = 16'h0000;
        stall_bad = 0;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            if (mem_ready || if_ready || !sram_ce_n) stall_bad++;
        end
        chk("abort_no_ready", 32'(stall_bad), 32'd0);
        run_and_check(1'b0, 1'b0, 16'h0006, 16'h0000, ref_mem[6]);

        // Simultaneous requests: data stage first, fetch one full access later.
        km = -1; ki = -1; stall_bad = 0;
        mem_req = 1'b1; mem_we = 1'b0; mem_addr = 16'h000F;
        if_req = 1'b1; if_addr = 16'h0004;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (if_ready) begin
                ki = k;
                chk("conf_if_stall_at_ready", 32'(if_stall), 32'd0);
                chk("conf_if_rdata", 32'(if_rdata), 32'(ref_mem[4]));
                if_req = 1'b0;
                break;
            end
            if (if_stall !== 1'b1) stall_bad++;
            if (mem_ready) begin
                km = k;
                chk("conf_mem_rdata", 32'(mem_rdata), 32'(ref_mem[15]));
                mem_req = 1'b0;
            end
        end
        chk("conf_mem_lat", 32'(km + 1), 32'(W + 2));
        chk("conf_if_gap", 32'(ki - km), 32'(W + 3));
        chk("conf_stall_errs", 32'(stall_bad), 32'd0);
`ifdef MEM_ARBITER_CONFLICT_CNT_EN
        chk("conflict_cnt", 32'(conflict_cnt), 32'd1);
`else
        chk("conflict_cnt", 32'(conflict_cnt), 32'd0);
`endif
        @(posedge clk); #1;

        // Back-to-back fetches with if_req held: spacing is one full access plus IDLE.
        k1 = -1; k2 = -1;
        if_req = 1'b1; if_addr = 16'h0000;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (if_ready) begin
                if (k1 < 0) begin
                    k1 = k;
                    chk("b2b_first_data", 32'(if_rdata), 32'(ref_mem[0]));
                    if_addr = 16'h0004;
                end else begin
                    k2 = k;
                    chk("b2b_second_data", 32'(if_rdata), 32'(ref_mem[4]));
                    if_req = 1'b0;
                    break;
                end
            end
        end
        if_req = 1'b0;
        chk("b2b_spacing", 32'(k2 - k1), 32'(W + 3));

        k1 = -1; k2 = -1;
        d0_if_req = 1'b1; d0_if_addr = 16'h0000;
        for (int k = 0; k < 30; k++) begin
            @(posedge clk); #1;
            if (d0_if_ready) begin
                if (k1 < 0) begin
                    k1 = k;
                    chk("w0_first_data", 32'(d0_if_rdata), 32'h5A5A);
                    d0_if_addr = 16'h0004;
                end else begin
                    k2 = k;
                    chk("w0_second_data", 32'(d0_if_rdata), 32'h5A5E);
                    d0_if_req = 1'b0;
                    break;
                end
            end
        end
        d0_if_req = 1'b0;
        chk("w0_first_lat", 32'(k1 + 1), 32'd2);
        chk("w0_spacing", 32'(k2 - k1), 32'd3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
